// File: rtl/ship_placement_ctrl.sv
// ship_placement_ctrl
// Sequences the placement of a five-ship fleet onto a GRID_N x GRID_N map.
// Each request is first bounds-checked at capture. It then spends one cycle
// per segment cell looking for collisions with ships already on the map. It
// finishes with a single RESP cycle that either commits the ship or reports
// why the request was rejected.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-low reset
//   start        begin a session: clear the map, select ship 0
//   place_valid  placement request present
//   place_row    bow row of the request
//   place_col    bow column of the request
//   place_vert   0 = ship extends along columns, 1 = along rows
//   place_ready  request accepted this cycle (WAIT only)
//   ship_idx     ship being placed: carrier, battleship, cruiser, sub, destroyer
//   place_ack    one-cycle pulse: request committed
//   place_err    one-cycle pulse: request rejected
//   err_code     01 out of bounds, 10 overlap, 11 spacing; 00 unless place_err
//   ship_map     bit row*GRID_N+col set when that cell holds a ship
//   done         all five ships placed
//
// Build option: define SHIP_SPACING_EN so that ships may not touch
// orthogonally (err_code 11).
module ship_placement_ctrl #(
    parameter int GRID_N = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     place_valid,
    input  logic [3:0]               place_row,
    input  logic [3:0]               place_col,
    input  logic                     place_vert,
    output logic                     place_ready,
    output logic [2:0]               ship_idx,
    output logic                     place_ack,
    output logic                     place_err,
    output logic [1:0]               err_code,
    output logic [GRID_N*GRID_N-1:0] ship_map,
    output logic                     done
);
    localparam int MAP_W = GRID_N * GRID_N;
    localparam int IDX_W = $clog2(MAP_W);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OOB  = 2'b01;
    localparam logic [1:0] ERR_OVL  = 2'b10;
    localparam logic [1:0] ERR_SPC  = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT, CHECK, RESP, DONE} state_t;
    state_t state, state_nx;

    // Captured request and per-check bookkeeping.
    logic [3:0]       cur_row, cur_col;
    logic             cur_vert;
    logic [2:0]       step;
    logic             ovl_flag, spc_flag;
    logic [1:0]       resp_code;

    logic [2:0]       ship_len;
    logic             req_oob;
    int               seg_r, seg_c;
    logic             hit_ovl, hit_spc, ovl_now, spc_now, last_step;
    logic [MAP_W-1:0] seg_mask;
    logic             capture;

    function automatic logic [2:0] len_of(input logic [2:0] idx);
        case (idx)
            3'd0:       return 3'd5;
            3'd1:       return 3'd4;
            3'd2, 3'd3: return 3'd3;
            default:    return 3'd2;
        endcase
    endfunction

    // Cells outside the grid read as empty, so edge neighbours need no
    // special casing in the spacing check.
    function automatic logic occ(input logic [MAP_W-1:0] m, input int r, input int c);
        logic hit;
        hit = 1'b0;
        if (r >= 0 && r < GRID_N && c >= 0 && c < GRID_N)
            hit = m[IDX_W'(r * GRID_N + c)];
        return hit;
    endfunction

    assign ship_len = len_of(ship_idx);

    // The along-axis test covers the whole ship. The cross-axis test only
    // needs the bow, because that coordinate stays fixed along the ship.
    assign req_oob =
        ((place_vert ? int'(place_row) : int'(place_col)) + int'(ship_len) > GRID_N) ||
        ((place_vert ? int'(place_col) : int'(place_row)) >= GRID_N);

    // The segment cell examined in the current CHECK cycle.
    assign seg_r = int'(cur_row) + (cur_vert ? int'(step) : 0);
    assign seg_c = int'(cur_col) + (cur_vert ? 0 : int'(step));

    assign hit_ovl = occ(ship_map, seg_r, seg_c);
`ifdef SHIP_SPACING_EN
    // The ship's own earlier cells are not on the map yet, so any occupied
    // neighbour belongs to another ship.
    assign hit_spc = occ(ship_map, seg_r - 1, seg_c) | occ(ship_map, seg_r + 1, seg_c) |
                     occ(ship_map, seg_r, seg_c - 1) | occ(ship_map, seg_r, seg_c + 1);
`else
    assign hit_spc = 1'b0;
`endif

    assign ovl_now   = ovl_flag | hit_ovl;
    assign spc_now   = spc_flag | hit_spc;
    assign last_step = (step == ship_len - 3'd1);

    // Every cell of the captured ship. This is only committed after all
    // cells have passed, which implies the request was in bounds.
    always_comb begin
        seg_mask = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(ship_len))
                seg_mask[IDX_W'((int'(cur_row) + (cur_vert ? k : 0)) * GRID_N +
                                int'(cur_col) + (cur_vert ? 0 : k))] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        place_ready = 1'b0;
        place_ack   = 1'b0;
        place_err   = 1'b0;
        err_code    = ERR_NONE;
        done        = 1'b0;
        capture     = 1'b0;

        case (state)
            IDLE: ;
            WAIT: begin
                place_ready = 1'b1;
                if (place_valid) begin
                    capture  = 1'b1;
                    state_nx = req_oob ? RESP : CHECK;
                end
            end
            CHECK: if (last_step) state_nx = RESP;
            RESP: begin
                place_ack = (resp_code == ERR_NONE);
                place_err = (resp_code != ERR_NONE);
                err_code  = resp_code;
                // ship_idx was already advanced when the ship was committed.
                state_nx  = (ship_idx == 3'd5) ? DONE : WAIT;
            end
            DONE: done = 1'b1;
            default: state_nx = IDLE;
        endcase

        // start overrides everything, including a handshake in the same cycle.
        if (start) begin
            capture  = 1'b0;
            state_nx = WAIT;
        end
    end

    // NOTE: the map is an ordinary flop vector rather than a RAM, so the
    // whole of it can be cleared by reset or start in a single cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ship_map  <= '0;
            ship_idx  <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            cur_vert  <= 1'b0;
            step      <= '0;
            ovl_flag  <= 1'b0;
            spc_flag  <= 1'b0;
            resp_code <= ERR_NONE;
        end else if (start) begin
            ship_map  <= '0;
            ship_idx  <= '0;
            step      <= '0;
            ovl_flag  <= 1'b0;
            spc_flag  <= 1'b0;
            resp_code <= ERR_NONE;
        end else begin
            if (capture) begin
                cur_row   <= place_row;
                cur_col   <= place_col;
                cur_vert  <= place_vert;
                step      <= '0;
                ovl_flag  <= 1'b0;
                spc_flag  <= 1'b0;
                resp_code <= req_oob ? ERR_OOB : ERR_NONE;
            end
            if (state == CHECK) begin
                step     <= step + 3'd1;
                ovl_flag <= ovl_now;
                spc_flag <= spc_now;
                // The verdict folds in the last cell examined in this cycle,
                // so a commit is visible in the RESP cycle itself.
                if (last_step) begin
                    if (ovl_now) begin
                        resp_code <= ERR_OVL;
                    end else if (spc_now) begin
                        resp_code <= ERR_SPC;
                    end else begin
                        resp_code <= ERR_NONE;
                        ship_map  <= ship_map | seg_mask;
                        ship_idx  <= ship_idx + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ship_placement_ctrl.sv
module tb_ship_placement_ctrl;
    localparam int GRID_N = 10;
    localparam int MAP_W  = GRID_N * GRID_N;
    localparam int IDX_W  = $clog2(MAP_W);

    logic             clk = 1'b0;
    logic             reset, start, place_valid, place_vert;
    logic [3:0]       place_row, place_col;
    logic             place_ready, place_ack, place_err, done;
    logic [2:0]       ship_idx;
    logic [1:0]       err_code;
    logic [MAP_W-1:0] ship_map;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        bit         ack;
        logic [1:0] code;
        int         at;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       vert;
        bit         ack;
        logic [1:0] code;
        int         lat;
    } vec_t;
    vec_t vecs[11];

    ship_placement_ctrl #(.GRID_N(GRID_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .place_valid (place_valid),
        .place_row   (place_row),
        .place_col   (place_col),
        .place_vert  (place_vert),
        .place_ready (place_ready),
        .ship_idx    (ship_idx),
        .place_ack   (place_ack),
        .place_err   (place_err),
        .err_code    (err_code),
        .ship_map    (ship_map),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_resp(input bit ack, input logic [1:0] code, input int at);
        resp_t e;
        e.ack  = ack;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Response monitor: every ack/err must match the oldest expectation.
    always @(negedge clk) begin
        resp_t e;
        if (place_ack || place_err) begin
            check("ack_err_exclusive", place_ack & place_err, 0);
            if (sb.size() == 0) begin
                check("unexpected_response", {place_ack, place_err}, 0);
            end else begin
                e = sb.pop_front();
                check("resp_kind", place_ack, e.ack);
                check("resp_code", err_code, e.code);
                check("resp_cycle", cyc, e.at);
            end
        end
    end

    // Drive one request in the first cycle with place_ready high. t is the
    // handshake cycle. The fields are scrambled afterwards to prove that
    // they were captured at the handshake.
    task automatic handshake(input logic [3:0] r, input logic [3:0] c, input logic v,
                             output int t);
        int n = 0;
        @(negedge clk);
        while (!place_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!place_ready) check("ready_timeout", 0, 1);
        place_row   = r;
        place_col   = c;
        place_vert  = v;
        place_valid = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        place_valid = 1'b0;
        place_row   = 4'($urandom);
        place_col   = 4'($urandom);
        place_vert  = 1'($urandom);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic place(input logic [3:0] r, input logic [3:0] c, input logic v,
                         input bit ack, input logic [1:0] code, input int lat);
        int t;
        handshake(r, c, v, t);
        expect_resp(ack, code, t + lat);
        wait_resp();
        @(negedge clk);
    endtask

    initial begin
        int t;
        int idx_model;
        int lens[5];
        logic [MAP_W-1:0] model;
        logic [MAP_W-1:0] held;

        lens = '{5, 4, 3, 3, 2};
        //           row    col   vert  ack   code   lat
        vecs[0]  = '{4'd0,  4'd6, 1'b0, 1'b0, 2'b01, 1};   // carrier past right edge
        vecs[1]  = '{4'd0,  4'd0, 1'b0, 1'b1, 2'b00, 6};   // carrier ok
        vecs[2]  = '{4'd0,  4'd7, 1'b0, 1'b0, 2'b01, 1};   // battleship past edge
        vecs[3]  = '{4'd0,  4'd3, 1'b1, 1'b0, 2'b10, 5};   // battleship overlaps carrier
        vecs[4]  = '{4'd2,  4'd0, 1'b0, 1'b1, 2'b00, 5};   // battleship ok
        vecs[5]  = '{4'd2,  4'd2, 1'b1, 1'b0, 2'b10, 4};   // cruiser overlaps battleship
        vecs[6]  = '{4'd4,  4'd0, 1'b1, 1'b1, 2'b00, 4};   // cruiser ok
        vecs[7]  = '{4'd15, 4'd0, 1'b0, 1'b0, 2'b01, 1};   // sub row off grid
        vecs[8]  = '{4'd9,  4'd7, 1'b0, 1'b1, 2'b00, 4};   // sub flush with right edge
        vecs[9]  = '{4'd9,  4'd0, 1'b1, 1'b0, 2'b01, 1};   // destroyer past bottom
        vecs[10] = '{4'd0,  4'd9, 1'b1, 1'b1, 2'b00, 3};   // destroyer ok

        reset = 1'b0;
        start = 1'b1;            // start held during reset must lose
        place_valid = 1'b0;
        place_row = '0;
        place_col = '0;
        place_vert = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", place_ready, 0);
        check("rst_ack", place_ack, 0);
        check("rst_err", place_err, 0);
        check("rst_code", err_code, 0);
        check("rst_idx", ship_idx, 0);
        check("rst_map", ship_map, 0);
        check("rst_done", done, 0);
        start = 1'b0;
        reset = 1'b1;

        // IDLE ignores requests until start.
        place_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", place_ready, 0);
        place_valid = 1'b0;

        do_start();
        @(negedge clk);
        check("start_ready", place_ready, 1);

        // Table-driven fleet placement with rejections interleaved.
        model = '0;
        idx_model = 0;
        for (int i = 0; i < 11; i++) begin
            place(vecs[i].row, vecs[i].col, vecs[i].vert, vecs[i].ack, vecs[i].code, vecs[i].lat);
            if (vecs[i].ack) begin
                for (int k = 0; k < lens[idx_model]; k++)
                    model[IDX_W'((int'(vecs[i].row) + (vecs[i].vert ? k : 0)) * GRID_N +
                                 int'(vecs[i].col) + (vecs[i].vert ? 0 : k))] = 1'b1;
                idx_model++;
            end
            check("vec_ship_idx", ship_idx, idx_model);
            check("vec_ship_map", ship_map, model);
        end
        check("fleet_done", done, 1);
        check("fleet_ready", place_ready, 0);
        check("fleet_popcount", $countones(ship_map), 17);

        // DONE ignores further requests and holds the map.
        place_valid = 1'b1;
        place_row = 4'd5;
        place_col = 4'd5;
        repeat (8) @(negedge clk);
        place_valid = 1'b0;
        check("done_hold", done, 1);
        check("done_map_hold", ship_map, model);

        // start during the second CHECK cycle aborts the pending request.
        do_start();
        @(negedge clk);
        check("restart_map", ship_map, 0);
        check("restart_idx", ship_idx, 0);
        check("restart_done", done, 0);
        place(4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 6);
        held = ship_map;
        check("carrier_map", held, 100'h1F);
        handshake(4'd2, 4'd0, 1'b0, t);   // cycle t+1 is the first CHECK cycle
        @(posedge clk);
        #1;
        start = 1'b1;                    // asserted in the second CHECK cycle
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("abort_map", ship_map, 0);
        check("abort_idx", ship_idx, 0);
        check("abort_ready", place_ready, 1);
        repeat (8) @(negedge clk);

        // Carrier then a battleship directly underneath it.
        place(4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 6);
`ifdef SHIP_SPACING_EN
        place(4'd1, 4'd0, 1'b0, 1'b0, 2'b11, 5);
        check("adjacent_map", ship_map, 100'h1F);
        check("adjacent_idx", ship_idx, 1);
`else
        place(4'd1, 4'd0, 1'b0, 1'b1, 2'b00, 5);
        check("adjacent_map", ship_map, 100'h3C1F);
        check("adjacent_idx", ship_idx, 2);
`endif

        // start and a handshake in the same cycle: the request is discarded.
        do_start();
        @(negedge clk);
        place_row = 4'd5;
        place_col = 4'd5;
        place_vert = 1'b0;
        place_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        place_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("collide_ready", place_ready, 1);
        check("collide_map", ship_map, 0);
        repeat (8) @(negedge clk);

        // reset in the middle of CHECK.
        handshake(4'd3, 4'd3, 1'b1, t);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", place_ready, 0);
        check("midrst_map", ship_map, 0);
        check("midrst_idx", ship_idx, 0);
        check("midrst_done", done, 0);
        repeat (8) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
